// File: rtl/tedv3_output_port.sv
// rtl/tedv3_output_port.sv - Avalon-MM PIO output port with valid/ready handoff and status IRQ
//
// Ports:
//   clk, reset_n    clock (rising edge), asynchronous active-low reset
//   address[1:0]    0 DATA, 1 STATUS, 2 OUTSET, 3 OUTCLR
//   chipselect      slave select; write_n is the active-low write strobe
//   writedata[31:0] write data; bits at or above WIDTH are dropped
//   readdata[31:0]  registered read data, one cycle after the address
//   out_port        current data register
//   out_valid       a new value is waiting for the consumer
//   out_ready       consumer takes the pending value
//   irq             level interrupt, done & irq_en

module tedv3_output_port #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_OUTSET = 2'd2;
  localparam logic [1:0] ADDR_OUTCLR = 2'd3;

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      data_ext;
  logic [31:0]      readdata_next;
  logic             done, done_next;
  logic             overflow, overflow_next;
  logic             irq_en, irq_en_next;
  logic             wr;
  logic             update;
  logic             status_wr;

  assign wr        = chipselect & ~write_n;
  assign status_wr = wr & (address == ADDR_STATUS);
  // Every non-STATUS write counts as a new value, even an OUTSET/OUTCLR of zero.
  assign update    = wr & (address != ADDR_STATUS);
  assign wdata     = writedata[WIDTH-1:0];

  assign out_port  = data_reg;
  assign out_valid = (state == PEND);
  assign irq       = done & irq_en;

  always_comb begin
    data_ext = '0;
    data_ext[WIDTH-1:0] = data_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_reg <= RESET_VALUE;
      done     <= 1'b0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      readdata <= '0;
    end else begin
      state    <= state_next;
      data_reg <= data_next;
      done     <= done_next;
      overflow <= overflow_next;
      irq_en   <= irq_en_next;
      readdata <= readdata_next;
    end
  end

  always_comb begin
    state_next    = state;
    data_next     = data_reg;
    done_next     = done;
    overflow_next = overflow;
    irq_en_next   = irq_en;

    // W1C clears first so a same-cycle set below wins.
    if (status_wr) begin
      irq_en_next = writedata[8];
      if (writedata[2]) done_next = 1'b0;
      if (writedata[1]) overflow_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (update) state_next = PEND;
      end
      PEND: begin
        // The value on out_port this cycle is taken; a same-edge update stays pending.
        if (out_ready) done_next = 1'b1;
        if (update && !out_ready) overflow_next = 1'b1;
        if (out_ready && !update) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (update) begin
      case (address)
        ADDR_DATA:   data_next = wdata;
        ADDR_OUTSET: data_next = data_reg | wdata;
        ADDR_OUTCLR: data_next = data_reg & ~wdata;
        default:     data_next = data_reg;
      endcase
    end
  end

  // Read mux sees pre-edge state, so a write shows up on the following read.
  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:   readdata_next = data_ext;
      ADDR_STATUS: readdata_next = {23'b0, irq_en, 5'b0, done, overflow, out_valid};
      default:     readdata_next = '0;
    endcase
  end

endmodule
